// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - shares one AXI master port between icache reads and dcache reads/writes
//
// Purpose: turns icache/dcache read requests into AXI AR bursts, routes R beats back by
// ID, and buffers one 128-bit dcache write (line or uncached word) onto AW/W/B.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating read grant instead of dcache-first).
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   ic_rd_* / ic_rd_rdy              icache read request and one-cycle accept pulse
//   ic_ret_*                         icache return beat (combinational from R)
//   dc_rd_* / dc_rd_rdy              dcache read request and one-cycle accept pulse
//   dc_ret_*                         dcache return beat (combinational from R)
//   dc_wr_* / dc_wr_rdy              dcache write request, rdy high while write buffer free
//   ar*, r*, aw*, w*, b*             AXI master channels (burst/lock/cache/prot tied at top)
module cache_axi_arbiter #(
  parameter logic [3:0] ICACHE_ID = 4'd0,
  parameter logic [3:0] DCACHE_ID = 4'd1,
  parameter logic [3:0] WR_ID     = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  // type[2] selects a 4-beat line burst; otherwise a single beat of size type[1:0]
  function automatic logic [7:0] dec_len(input logic [2:0] t);
    return t[2] ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] dec_size(input logic [2:0] t);
    return t[2] ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  ar_state_t      ar_state;
  w_state_t       w_state;
  logic           ic_out;
  logic           dc_out;
  logic [31:0]    wr_addr_q;
  logic           wr_line;
  logic [3:0]     wr_strb_q;
  logic [127:0]   wr_data_q;
  logic [1:0]     w_cnt;
  logic           wr_busy;
  logic           ic_elig;
  logic           dc_elig;
  logic           grant_ic;
  logic           grant_dc;

  // R channel: always accept, steer each beat by ID, drop unknown IDs
  assign rready       = 1'b1;
  assign ic_ret_valid = rvalid && (rid == ICACHE_ID);
  assign ic_ret_last  = rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_valid = rvalid && (rid == DCACHE_ID);
  assign dc_ret_last  = rlast;
  assign dc_ret_data  = rdata;

  // Read-after-write: a read to the line held in the write buffer waits for B
  assign wr_busy = (w_state != W_IDLE);
  assign ic_elig = ic_rd_req && !ic_out &&
                   !(wr_busy && (ic_rd_addr[31:4] == wr_addr_q[31:4]));
  assign dc_elig = dc_rd_req && !dc_out &&
                   !(wr_busy && (dc_rd_addr[31:4] == wr_addr_q[31:4]));

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = icache won the previous grant, so dcache has priority next
  logic last_grant_ic;

  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (ar_state == AR_IDLE) begin
      if (ic_elig && dc_elig) begin
        grant_dc = last_grant_ic;
        grant_ic = !last_grant_ic;
      end else begin
        grant_dc = dc_elig;
        grant_ic = ic_elig;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      last_grant_ic <= 1'b1;
    else if (grant_ic || grant_dc)
      last_grant_ic <= grant_ic;
  end
`else
  always_comb begin
    grant_dc = 1'b0;
    grant_ic = 1'b0;
    if (ar_state == AR_IDLE) begin
      grant_dc = dc_elig;
      grant_ic = ic_elig && !dc_elig;
    end
  end
`endif

  assign ic_rd_rdy = grant_ic;
  assign dc_rd_rdy = grant_dc;

  // Read address FSM and per-cache outstanding flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      arid     <= 4'd0;
      araddr   <= 32'd0;
      arlen    <= 8'd0;
      arsize   <= 3'd0;
      ic_out   <= 1'b0;
      dc_out   <= 1'b0;
    end else begin
      if (rvalid && rlast && (rid == ICACHE_ID)) ic_out <= 1'b0;
      if (rvalid && rlast && (rid == DCACHE_ID)) dc_out <= 1'b0;
      case (ar_state)
        AR_IDLE: begin
          if (grant_dc) begin
            arid     <= DCACHE_ID;
            araddr   <= dc_rd_addr;
            arlen    <= dec_len(dc_rd_type);
            arsize   <= dec_size(dc_rd_type);
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end else if (grant_ic) begin
            arid     <= ICACHE_ID;
            araddr   <= ic_rd_addr;
            arlen    <= dec_len(ic_rd_type);
            arsize   <= dec_size(ic_rd_type);
            arvalid  <= 1'b1;
            ar_state <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (arready) begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
            if (arid == DCACHE_ID) dc_out <= 1'b1;
            else                   ic_out <= 1'b1;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // Write path: AW then W beats from the latched 128-bit buffer, then B
  assign awid      = WR_ID;
  assign awaddr    = wr_addr_q;
  assign dc_wr_rdy = (w_state == W_IDLE);
  assign wdata     = wr_line ? wr_data_q[{w_cnt, 5'd0} +: 32] : wr_data_q[31:0];
  assign wstrb     = wr_line ? 4'hF : wr_strb_q;
  assign wlast     = ({6'd0, w_cnt} == awlen);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      wr_addr_q <= 32'd0;
      wr_line   <= 1'b0;
      wr_strb_q <= 4'd0;
      wr_data_q <= 128'd0;
      awlen     <= 8'd0;
      awsize    <= 3'd0;
      w_cnt     <= 2'd0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (dc_wr_req) begin
            wr_addr_q <= dc_wr_addr;
            wr_line   <= dc_wr_type[2];
            wr_strb_q <= dc_wr_wstrb;
            wr_data_q <= dc_wr_data;
            awlen     <= dec_len(dc_wr_type);
            awsize    <= dec_size(dc_wr_type);
            awvalid   <= 1'b1;
            w_state   <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            w_cnt   <= 2'd0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wready) begin
            w_cnt <= w_cnt + 2'd1;
            if (wlast) begin
              wvalid  <= 1'b0;
              bready  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - self-checking bench for cache_axi_arbiter
module tb_cache_axi_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ic_rd_req;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr;
  logic         ic_rd_rdy;
  logic         ic_ret_valid;
  logic         ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_req;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr;
  logic         dc_rd_rdy;
  logic         dc_ret_valid;
  logic         dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         dc_wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic         bvalid;
  logic         bready;

  int checks = 0;
  int errors = 0;

  cache_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] data;
  } rd_vec_t;

  typedef struct {
    logic [3:0]  id;
    logic        last;
    logic [31:0] data;
    logic        exp_ic;
    logic        exp_dc;
  } r_vec_t;

  rd_vec_t rd_tab[4];
  r_vec_t  r_tab[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ar_accept(input logic [3:0] exp_id);
    chk("arvalid_before_hs", arvalid, 1'b1);
    chk("arid", arid, exp_id);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("arvalid_after_hs", arvalid, 1'b0);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic last, input logic [31:0] data);
    rvalid = 1'b1; rid = id; rlast = last; rdata = data;
    #1;
    chk("r_ic_valid", ic_ret_valid, id == 4'd0);
    chk("r_dc_valid", dc_ret_valid, id == 4'd1);
    if (id == 4'd0) chk("r_ic_last", ic_ret_last, last);
    if (id == 4'd1) chk("r_dc_data", dc_ret_data, data);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wr_issue(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                          input logic [127:0] d);
    chk("wr_rdy_before_req", dc_wr_rdy, 1'b1);
    dc_wr_type = t; dc_wr_addr = a; dc_wr_wstrb = s; dc_wr_data = d; dc_wr_req = 1'b1;
    tick();
    dc_wr_req = 1'b0;
    #1;
    chk("wr_rdy_after_req", dc_wr_rdy, 1'b0);
    chk("awvalid_set", awvalid, 1'b1);
  endtask

  // Both caches request together; exp_dc_first says who must win.
  task automatic contend(input logic exp_dc_first);
    ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_3000; ic_rd_req = 1'b1;
    dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_4000; dc_rd_req = 1'b1;
    #1;
    chk("contend_dc_rdy", dc_rd_rdy, exp_dc_first);
    chk("contend_ic_rdy", ic_rd_rdy, !exp_dc_first);
    tick();
    if (exp_dc_first) dc_rd_req = 1'b0; else ic_rd_req = 1'b0;
    #1;
    chk("contend_loser_busy", exp_dc_first ? ic_rd_rdy : dc_rd_rdy, 1'b0);
    ar_accept(exp_dc_first ? 4'd1 : 4'd0);
    chk("contend_loser_rdy", exp_dc_first ? ic_rd_rdy : dc_rd_rdy, 1'b1);
    tick();
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    #1;
    ar_accept(exp_dc_first ? 4'd0 : 4'd1);
    r_beat(4'd1, 1'b0, 32'hD000_0001);
    r_beat(4'd0, 1'b1, 32'hC000_0001);
    r_beat(4'd1, 1'b1, 32'hD000_0002);
  endtask

  initial begin
    rd_tab[0] = '{3'b100, 32'h1C00_0040, 8'd3, 3'd2, 32'h0000_0A00};
    rd_tab[1] = '{3'b000, 32'h8000_0001, 8'd0, 3'd0, 32'h0000_0A01};
    rd_tab[2] = '{3'b001, 32'h8000_0002, 8'd0, 3'd1, 32'h0000_0A02};
    rd_tab[3] = '{3'b010, 32'hBFAF_0004, 8'd0, 3'd2, 32'h0000_0A03};
    r_tab[0]  = '{4'd0, 1'b0, 32'h1234_5678, 1'b1, 1'b0};
    r_tab[1]  = '{4'd1, 1'b0, 32'h9ABC_DEF0, 1'b0, 1'b1};
    r_tab[2]  = '{4'd7, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0};
    r_tab[3]  = '{4'd2, 1'b0, 32'h0BAD_0002, 1'b0, 1'b0};

    resetn = 1'b0;
    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
    tick(); tick();

    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_ic_ret_valid", ic_ret_valid, 1'b0);
    chk("rst_dc_ret_valid", dc_ret_valid, 1'b0);
    chk("rst_dc_wr_rdy", dc_wr_rdy, 1'b1);
    chk("rst_rready", rready, 1'b1);
    resetn = 1'b1;
    tick();

    // R routing, no clock edge consumed
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rid = r_tab[i].id; rlast = r_tab[i].last; rdata = r_tab[i].data;
      #1;
      chk("route_ic_valid", ic_ret_valid, r_tab[i].exp_ic);
      chk("route_dc_valid", dc_ret_valid, r_tab[i].exp_dc);
      if (r_tab[i].exp_ic) chk("route_ic_data", ic_ret_data, r_tab[i].data);
      if (r_tab[i].exp_dc) chk("route_dc_data", dc_ret_data, r_tab[i].data);
      rvalid = 1'b0;
      #1;
    end

    // Icache line read
    ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040; ic_rd_req = 1'b1;
    #1;
    chk("icl_rdy", ic_rd_rdy, 1'b1);
    tick();
    ic_rd_req = 1'b0;
    #1;
    chk("icl_rdy_pulse", ic_rd_rdy, 1'b0);
    chk("icl_araddr", araddr, 32'h1C00_0040);
    chk("icl_arlen", arlen, 8'd3);
    chk("icl_arsize", arsize, 3'd2);
    tick();
    chk("icl_ar_hold", araddr, 32'h1C00_0040);
    ar_accept(4'd0);
    ic_rd_req = 1'b1;
    #1;
    chk("icl_outstanding_block", ic_rd_rdy, 1'b0);
    ic_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rid = 4'd0; rlast = (i == 3); rdata = 32'hA0 + i;
      #1;
      chk("icl_ret_valid", ic_ret_valid, 1'b1);
      chk("icl_ret_last", ic_ret_last, i == 3);
      chk("icl_ret_data", ic_ret_data, 32'hA0 + i);
      chk("icl_dc_quiet", dc_ret_valid, 1'b0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    ic_rd_req = 1'b1;
    #1;
    chk("icl_outstanding_clear", ic_rd_rdy, 1'b1);
    ic_rd_req = 1'b0;
    #1;

    // First contention: icache won last, so dcache first in both builds
    contend(1'b1);

    // Dcache read type decode table
    for (int i = 0; i < 4; i++) begin
      dc_rd_type = rd_tab[i].typ; dc_rd_addr = rd_tab[i].addr; dc_rd_req = 1'b1;
      #1;
      chk("tab_dc_rdy", dc_rd_rdy, 1'b1);
      tick();
      dc_rd_req = 1'b0;
      #1;
      chk("tab_araddr", araddr, rd_tab[i].addr);
      chk("tab_arlen", arlen, rd_tab[i].len);
      chk("tab_arsize", arsize, rd_tab[i].size);
      ar_accept(4'd1);
      r_beat(4'd1, 1'b1, rd_tab[i].data);
    end

    // Second contention: dcache won last
`ifdef ARB_ROUND_ROBIN_EN
    contend(1'b0);
`else
    contend(1'b1);
`endif

    // Dirty line write
    wr_issue(3'b100, 32'h0000_0100, 4'h0,
             128'h44444444_33333333_22222222_11111111);
    chk("lw_awlen", awlen, 8'd3);
    chk("lw_awsize", awsize, 3'd2);
    chk("lw_awaddr", awaddr, 32'h0000_0100);
    chk("lw_awid", awid, 4'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wready = (i != 2);
      #1;
      if (i == 2) begin
        chk("lw_stall_data", wdata, 32'h33333333);
        tick();
        wready = 1'b1;
        #1;
      end
      chk("lw_wvalid", wvalid, 1'b1);
      chk("lw_wdata", wdata, 32'h11111111 * (i + 1));
      chk("lw_wstrb", wstrb, 4'hF);
      chk("lw_wlast", wlast, i == 3);
      chk("lw_wr_rdy_busy", dc_wr_rdy, 1'b0);
      tick();
    end
    wready = 1'b0;
    #1;
    chk("lw_wvalid_done", wvalid, 1'b0);
    chk("lw_bready", bready, 1'b1);
    chk("lw_wr_rdy_resp", dc_wr_rdy, 1'b0);
    tick();
    chk("lw_wr_rdy_wait_b", dc_wr_rdy, 1'b0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("lw_wr_rdy_free", dc_wr_rdy, 1'b1);
    chk("lw_bready_clr", bready, 1'b0);

    // Uncached store
    wr_issue(3'b010, 32'hBFAF_0004, 4'b0011, 128'h0000ABCD);
    chk("us_awlen", awlen, 8'd0);
    chk("us_awsize", awsize, 3'd2);
    chk("us_awaddr", awaddr, 32'hBFAF_0004);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("us_wvalid", wvalid, 1'b1);
    chk("us_wdata", wdata, 32'h0000ABCD);
    chk("us_wstrb", wstrb, 4'b0011);
    chk("us_wlast", wlast, 1'b1);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("us_bready", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("us_wr_rdy_free", dc_wr_rdy, 1'b1);

    // Read-after-write hazard
    wr_issue(3'b100, 32'h0000_1230, 4'h0, 128'h1);
    dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_1238; dc_rd_req = 1'b1;
    #1;
    chk("raw_dc_blocked", dc_rd_rdy, 1'b0);
    ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_2000; ic_rd_req = 1'b1;
    #1;
    chk("raw_ic_granted", ic_rd_rdy, 1'b1);
    tick();
    ic_rd_req = 1'b0;
    #1;
    chk("raw_ic_araddr", araddr, 32'h0000_2000);
    ar_accept(4'd0);
    chk("raw_dc_still_blocked", dc_rd_rdy, 1'b0);
    r_beat(4'd0, 1'b1, 32'hC0DE_0000);
    chk("raw_dc_blocked_aw", dc_rd_rdy, 1'b0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("raw_dc_blocked_w", dc_rd_rdy, 1'b0);
      tick();
    end
    wready = 1'b0;
    #1;
    chk("raw_dc_blocked_b", dc_rd_rdy, 1'b0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    #1;
    chk("raw_dc_released", dc_rd_rdy, 1'b1);
    dc_rd_req = 1'b0;
    #1;

    // Reset in the middle of a read burst with a write pending
    wr_issue(3'b100, 32'h0000_9000, 4'h0, 128'h2);
    dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_5000; dc_rd_req = 1'b1;
    #1;
    chk("mr_dc_rdy", dc_rd_rdy, 1'b1);
    tick();
    dc_rd_req = 1'b0;
    #1;
    ar_accept(4'd1);
    r_beat(4'd1, 1'b0, 32'h5000_0000);
    rvalid = 1'b1; rid = 4'd1; rlast = 1'b0; rdata = 32'h5000_0001;
    resetn = 1'b0;
    tick();
    rvalid = 1'b0;
    #1;
    chk("mr_arvalid", arvalid, 1'b0);
    chk("mr_awvalid", awvalid, 1'b0);
    chk("mr_wvalid", wvalid, 1'b0);
    chk("mr_bready", bready, 1'b0);
    chk("mr_dc_ret_valid", dc_ret_valid, 1'b0);
    chk("mr_ic_ret_valid", ic_ret_valid, 1'b0);
    chk("mr_dc_wr_rdy", dc_wr_rdy, 1'b1);
    resetn = 1'b1;
    tick();
    dc_rd_req = 1'b1;
    #1;
    chk("mr_dc_out_cleared", dc_rd_rdy, 1'b1);
    dc_rd_req = 1'b0;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
